// File: rtl/pe_pkg.sv
// Shared definitions for PE-array endpoints: drain FSM states and the
// accumulator-to-fixed-point saturate/truncate conversion.
package pe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CAPT,
        ST_DRAIN,
        ST_DONE
    } drain_state_e;

    // Accumulator carries 2*fra_bw fraction bits; the result keeps fra_bw.
    // Callers size-cast the 64-bit result down to their output word width.
    function automatic logic signed [63:0] sat_trunc(
        input  logic signed [63:0] acc,
        input  int                 int_bw,
        input  int                 fra_bw,
        output logic               saturated
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] res;
        int                 s;
        s         = int_bw + 2 * fra_bw;
        hi        = (64'sd1 <<< s) - 64'sd1;
        lo        = -(64'sd1 <<< s);
        saturated = 1'b0;
        if (acc > hi) begin
            res       = (64'sd1 <<< (int_bw + fra_bw)) - 64'sd1;
            saturated = 1'b1;
        end else if (acc < lo) begin
            res       = -(64'sd1 <<< (int_bw + fra_bw));
            saturated = 1'b1;
        end else begin
            res = acc >>> fra_bw;
        end
        return res;
    endfunction

endpackage

// File: rtl/pe_col_drain_if.sv
// Downstream result stream of the column drain: FWFT data with valid/ready.
interface pe_col_drain_if #(
    parameter int MUL_BW = 16
);
    logic signed [MUL_BW-1:0] dout;
    logic                     dout_valid;
    logic                     dout_ready;

    modport master (output dout, output dout_valid, input dout_ready);
    modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/pe_drain_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO only
// succeeds when a pop frees a slot on the same edge.
module pe_drain_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_en;
    logic          pop_en;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW + 1)'(DEPTH));
    assign pop_en  = pop && !empty;
    assign push_en = push && (!full || pop_en);
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/pe_col_drain.sv
// Captures a programmed window of one PE column's accumulator stream,
// converts each value to fixed point and queues it for downstream.
module pe_col_drain
    import pe_pkg::*;
#(
    parameter int INT_BW = 5,
    parameter int FRA_BW = 5,
    parameter int MUL_BW = 16,
    parameter int ACC_BW = 32,
    parameter int DEPTH  = 8,
    parameter int LAT_BW = 8,
    parameter int CNT_BW = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [LAT_BW-1:0]        lat,
    input  logic [CNT_BW-1:0]        len,
    input  logic signed [ACC_BW-1:0] o_i,
    pe_col_drain_if.master           dout_if,
    output logic                     busy,
    output logic                     done,
    output logic                     sat,
    output logic                     ovf
);
    drain_state_e      state_q, state_d;
    logic [LAT_BW-1:0] lat_cnt_q, lat_cnt_d;
    logic [CNT_BW-1:0] cap_cnt_q, cap_cnt_d;
    logic              sat_q, sat_d;
    logic              ovf_q, ovf_d;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              conv_sat;
    logic [MUL_BW-1:0] fifo_din;
    logic [MUL_BW-1:0] fifo_dout;

    always_comb begin
        conv_sat = 1'b0;
        fifo_din = MUL_BW'(sat_trunc(64'(o_i), INT_BW, FRA_BW, conv_sat));
    end

    assign pop                = dout_if.dout_valid && dout_if.dout_ready;
    assign dout_if.dout_valid = !fifo_empty;
    assign dout_if.dout       = fifo_dout;
    assign sat                = sat_q;
    assign ovf                = ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            lat_cnt_q <= '0;
            cap_cnt_q <= '0;
            sat_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            cap_cnt_q <= cap_cnt_d;
            sat_q     <= sat_d;
            ovf_q     <= ovf_d;
        end
    end

    // WAIT leaves after lat edges so the first capture lands on edge k+1+lat.
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        cap_cnt_d = cap_cnt_q;
        sat_d     = sat_q;
        ovf_d     = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    lat_cnt_d = lat;
                    cap_cnt_d = len;
                    sat_d     = 1'b0;
                    ovf_d     = 1'b0;
                    if (len == '0) begin
                        state_d = ST_DONE;
                    end else if (lat == '0) begin
                        state_d = ST_CAPT;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                lat_cnt_d = lat_cnt_q - LAT_BW'(1);
                if (lat_cnt_q == LAT_BW'(1)) begin
                    state_d = ST_CAPT;
                end
            end
            ST_CAPT: begin
                cap_cnt_d = cap_cnt_q - CNT_BW'(1);
                if (cap_cnt_q == CNT_BW'(1)) begin
                    state_d = ST_DRAIN;
                end
                if (conv_sat) begin
                    sat_d = 1'b1;
                end
                if (fifo_full && !pop) begin
                    ovf_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        push = (state_q == ST_CAPT);
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DONE);
    end

    pe_drain_fifo #(
        .W    (MUL_BW),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .din  (fifo_din),
        .pop  (pop),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

endmodule

// File: tb/tb_pe_col_drain.sv
// Directed self-checking bench for pe_col_drain with hand-computed results.
module tb_pe_col_drain;
    logic               clk;
    logic               rst;
    logic               start;
    logic [7:0]         lat;
    logic [7:0]         len;
    logic signed [31:0] o_i;
    logic               busy;
    logic               done;
    logic               sat;
    logic               ovf;
    int                 errors;
    int                 checks;

    pe_col_drain_if #(.MUL_BW(16)) dif ();

    pe_col_drain dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .lat    (lat),
        .len    (len),
        .o_i    (o_i),
        .dout_if(dif.master),
        .busy   (busy),
        .done   (done),
        .sat    (sat),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if ({dif.dout, dif.dout_valid, busy, done, sat, ovf} !== 21'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected 0",
                     {dif.dout, dif.dout_valid, busy, done, sat, ovf});
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({dif.dout_valid, busy, done} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_idle: got %b expected 000", {dif.dout_valid, busy, done});
        end
    endtask

    // Ramp o_i = j*1024 on edge k+j; a second start mid-job must be ignored.
    task automatic test_capture_window();
        logic        exp_valid;
        logic [15:0] exp_dout;
        dif.dout_ready = 1'b1;
        lat = 8'd3;
        len = 8'd4;
        for (int j = 0; j <= 12; j++) begin
            start = (j == 0 || j == 5);
            o_i   = j * 1024;
            tick();
            exp_valid = (j >= 4 && j <= 7);
            exp_dout  = exp_valid ? 16'(j * 32) : 16'h0;
            checks++;
            if (dif.dout_valid !== exp_valid || dif.dout !== exp_dout) begin
                errors++;
                $display("[TB] FAIL ramp_dout j=%0d: got v=%b d=%h expected v=%b d=%h",
                         j, dif.dout_valid, dif.dout, exp_valid, exp_dout);
            end
            checks++;
            if (done !== (j == 9) || busy !== (j <= 9)) begin
                errors++;
                $display("[TB] FAIL ramp_ctrl j=%0d: got done=%b busy=%b expected done=%b busy=%b",
                         j, done, busy, (j == 9), (j <= 9));
            end
        end
        start = 1'b0;
        checks++;
        if (sat !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ramp_flags: got sat=%b ovf=%b expected 0 0", sat, ovf);
        end
    endtask

    task automatic test_zero_len();
        lat   = 8'd5;
        len   = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({done, busy, dif.dout_valid} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL zero_len_first: got %b expected 110", {done, busy, dif.dout_valid});
        end
        tick();
        checks++;
        if ({done, busy, dif.dout_valid} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL zero_len_after: got %b expected 000", {done, busy, dif.dout_valid});
        end
    endtask

    task automatic test_saturate();
        int n;
        dif.dout_ready = 1'b0;
        lat   = 8'd0;
        len   = 8'd2;
        o_i   = 32'sd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        o_i   = 32'sh0010_0000;
        tick();
        checks++;
        if (dif.dout !== 16'h03FF || dif.dout_valid !== 1'b1 || sat !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sat_pos: got d=%h v=%b sat=%b expected 03ff 1 1",
                     dif.dout, dif.dout_valid, sat);
        end
        o_i = 32'shFFF0_0000;
        tick();
        dif.dout_ready = 1'b1;
        tick();
        checks++;
        if (dif.dout !== 16'hFC00 || dif.dout_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sat_neg: got d=%h v=%b expected fc00 1", dif.dout, dif.dout_valid);
        end
        n = 0;
        while (!done && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (done !== 1'b1 || sat !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sat_done: got done=%b sat=%b expected 1 1", done, sat);
        end
        tick();
    endtask

    task automatic test_convert();
        logic signed [31:0] vin [5];
        logic [15:0]        vexp[5];
        int                 n;
        vin  = '{32'sd32767, -32'sd32768, -32'sd1, -32'sd33, 32'sd100};
        vexp = '{16'h03FF, 16'hFC00, 16'hFFFF, 16'hFFFE, 16'h0003};
        dif.dout_ready = 1'b0;
        lat   = 8'd0;
        len   = 8'd5;
        o_i   = 32'sd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            o_i = vin[i];
            tick();
        end
        checks++;
        if (sat !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL conv_flags: got sat=%b ovf=%b expected 0 0", sat, ovf);
        end
        dif.dout_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (dif.dout !== vexp[i] || dif.dout_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL conv_%0d: got d=%h v=%b expected %h 1",
                         i, dif.dout, dif.dout_valid, vexp[i]);
            end
            tick();
        end
        n = 0;
        while (!done && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL conv_done: got %b expected 1", done);
        end
        tick();
    endtask

    task automatic test_overflow();
        int n;
        dif.dout_ready = 1'b0;
        lat   = 8'd0;
        len   = 8'd10;
        o_i   = 32'sd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            o_i = j * 32;
            tick();
        end
        for (int j = 0; j < 3; j++) tick();
        checks++;
        if ({ovf, busy, done, dif.dout_valid} !== 4'b1101 || dif.dout !== 16'h0001) begin
            errors++;
            $display("[TB] FAIL ovf_hold: got ovf/busy/done/v=%b d=%h expected 1101 0001",
                     {ovf, busy, done, dif.dout_valid}, dif.dout);
        end
        dif.dout_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if (dif.dout !== 16'(i) || dif.dout_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL ovf_pop_%0d: got d=%h v=%b expected %h 1",
                         i, dif.dout, dif.dout_valid, 16'(i));
            end
            tick();
        end
        n = 0;
        while (!done && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (done !== 1'b1 || dif.dout_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_done: got done=%b v=%b expected 1 0", done, dif.dout_valid);
        end
        tick();
    endtask

    // Fill to 8, then open ready on edge k+9 so pushes meet pops at full.
    task automatic test_back_to_back();
        int n;
        dif.dout_ready = 1'b0;
        lat   = 8'd0;
        len   = 8'd12;
        o_i   = 32'sd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            if (j == 9) dif.dout_ready = 1'b1;
            o_i = j * 32;
            tick();
            if (j >= 9) begin
                checks++;
                if (dif.dout !== 16'(j - 7)) begin
                    errors++;
                    $display("[TB] FAIL b2b_cap_%0d: got %h expected %h", j, dif.dout, 16'(j - 7));
                end
            end
        end
        for (int m = 1; m <= 8; m++) begin
            tick();
            checks++;
            if (m < 8 && dif.dout !== 16'(5 + m)) begin
                errors++;
                $display("[TB] FAIL b2b_drain_%0d: got %h expected %h", m, dif.dout, 16'(5 + m));
            end else if (m == 8 && dif.dout_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL b2b_empty: got v=%b expected 0", dif.dout_valid);
            end
        end
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_ovf: got %b expected 0", ovf);
        end
        n = 0;
        while (!done && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_done: got %b expected 1", done);
        end
        tick();
    endtask

    task automatic test_reset_mid_job();
        dif.dout_ready = 1'b0;
        lat   = 8'd0;
        len   = 8'd8;
        o_i   = 32'sd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        o_i   = 32'sh0010_0000;
        tick();
        o_i = 32'sd64;
        tick();
        o_i = 32'sd96;
        tick();
        checks++;
        if ({dif.dout_valid, sat, busy} !== 3'b111) begin
            errors++;
            $display("[TB] FAIL mid_pre: got %b expected 111", {dif.dout_valid, sat, busy});
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({dif.dout, dif.dout_valid, busy, done, sat, ovf} !== 21'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got %h expected 0",
                     {dif.dout, dif.dout_valid, busy, done, sat, ovf});
        end
        tick();
        rst = 1'b0;
        tick();
        test_capture_window();
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        rst            = 1'b1;
        start          = 1'b0;
        lat            = '0;
        len            = '0;
        o_i            = '0;
        dif.dout_ready = 1'b0;
        test_reset();
        test_capture_window();
        test_zero_len();
        test_saturate();
        test_convert();
        test_overflow();
        test_back_to_back();
        test_reset_mid_job();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pe_col_drain.md
Name: pe_col_drain

Overview:
- Read-side companion to the PE array. Captures the accumulator stream leaving the bottom PE of one column on its o_o output.
- Capture window opens a programmed number of cycles after a start pulse and lasts a programmed number of results.
- Each captured value is saturated/truncated from ACC_BW accumulator format to MUL_BW fixed point Q(INT_BW).(FRA_BW).
- Results are buffered in a small FIFO and handed downstream over a valid/ready handshake.

Parameters:
INT_BW, 5, integer bits of output fixed-point format
FRA_BW, 5, fraction bits of output format (accumulator carries 2*FRA_BW)
MUL_BW, 16, output word width; must be >= 1+INT_BW+FRA_BW
ACC_BW, 32, accumulator width from PE; must be >= INT_BW+2*FRA_BW+1
DEPTH, 8, FIFO entries (power of two, >= 2)
LAT_BW, 8, width of latency field
CNT_BW, 8, width of length field

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
start  input  1  one-cycle request to open a capture window
lat  input  LAT_BW  cycles between start edge and first capture; sampled with start
len  input  CNT_BW  number of results to capture; sampled with start
o_i  input  ACC_BW signed  accumulator from PE column output
dout  output  MUL_BW signed  FIFO head, saturated fixed point
dout_valid  output  1  FIFO non-empty
dout_ready  input  1  downstream accepts dout this cycle
busy  output  1  FSM not IDLE
done  output  1  one-cycle pulse at end of job
sat  output  1  sticky: at least one captured value saturated this job
ovf  output  1  sticky: at least one capture dropped because FIFO full

Behaviour:
- Reset (async, rst=1): FSM=IDLE, FIFO empty, counters 0. dout=0, dout_valid=0, busy=0, done=0, sat=0, ovf=0. Reset mid-job abandons the job and discards FIFO contents.
- Handshake: pop on any edge with dout_valid && dout_ready. First-word fall-through: dout is the head entry combinationally from storage. dout=0 when empty.
- FSM states: IDLE, WAIT, CAPT, DRAIN, DONE.
- IDLE:
  - start=1 latches lat and len, clears sat and ovf.
  - len==0 -> DONE.
  - else lat==0 -> CAPT.
  - else -> WAIT.
  - start outside IDLE is ignored (no effect on any state).
- Capture timing: start sampled at edge k; o_i captured at edges k+1+lat through k+lat+len, one per cycle, no gaps.
- WAIT: down-counts lat; enters CAPT so that the first capture lands on edge k+1+lat.
- CAPT: one capture per edge. After the len-th capture -> DRAIN.
- DRAIN: stays until FIFO empty, then -> DONE. If the FIFO is already empty when the last capture leaves it empty, DRAIN lasts exactly one cycle.
- DONE: done=1 for exactly one cycle, then -> IDLE. busy=1 in WAIT, CAPT, DRAIN, DONE.
- Conversion of o_i, with S = INT_BW+2*FRA_BW:
  - o_i > 2^S-1 -> dout = +(2^(INT_BW+FRA_BW)-1), sat set.
  - o_i < -2^S -> dout = -2^(INT_BW+FRA_BW), sat set.
  - else dout = o_i[S:FRA_BW] sign-extended to MUL_BW (truncate toward -inf).
- Full FIFO on a capture edge:
  - With a simultaneous pop: push succeeds, count unchanged.
  - Without a pop: sample dropped, ovf set, capture counter still advances.
- Empty FIFO: pop ignored. Push and pop on the same edge when empty: push only.
- FIFO pointers wrap modulo DEPTH. Occupancy counter width is log2(DEPTH)+1.

Decomposition:
- Shared package pe_pkg: drain FSM state enum; a saturate/truncate function parameterised by INT_BW/FRA_BW/MUL_BW/ACC_BW, reusable by other PE-array endpoints.
- One sub-module, pe_drain_fifo: synchronous FWFT FIFO with push, pop, full, empty and dout.

Test Plan:
1. lat=3, len=4, o_i=k*1024 for k=0..7 ramp, dout_ready=1 -> captured values are those present on edges k+4..k+7; dout=value>>5 each; done pulses once; sat=0, ovf=0.
2. len=0, start=1 -> done pulses at edge k+1; no dout_valid ever; busy high for exactly one cycle.
3. o_i=0x00100000 (>2^15-1) then o_i=0xFFF00000, lat=0, len=2 -> dout=0x03FF then 0xFC00; sat=1.
4. DEPTH=8, len=10, dout_ready=0 -> 8 entries held, ovf=1, FSM waits in DRAIN. Then dout_ready=1 -> 8 pops in order, then done.
5. FIFO full with dout_ready=1 during capture -> simultaneous push/pop; no drop, ovf=0.
6. rst asserted mid-CAPT with FIFO holding 3 entries -> all outputs 0 immediately. After release, start is accepted and the new job behaves as in scenario 1.
